// File: rtl/store_buffer_pkg.sv
// Shared definitions for the store buffer: access-size encoding, the entry
// record and the default geometry. Entry field widths bound the AW/DW parameters.
package mem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    localparam int SB_DEPTH = 4;
    localparam int SB_AW    = 32;
    localparam int SB_DW    = 32;

    typedef struct packed {
        logic             valid;
        logic [SB_AW-1:0] addr;
        logic [SB_DW-1:0] data;
        logic [1:0]       size;
    } sb_entry_t;

    // Size code 2'b11 is illegal and behaves as a word.
    function automatic logic [2:0] size_bytes(input logic [1:0] sz);
        case (sz)
            SZ_BYTE: return 3'd1;
            SZ_HALF: return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/store_buffer_if.sv
// Execute-side store port, memory-stage load query and DataMem write port of
// the store buffer; master is the pipeline side, slave is the buffer.
interface store_buffer_if #(
    parameter int AW = 32,
    parameter int DW = 32,
    parameter int CW = 3
);
    logic          st_valid;
    logic [AW-1:0] st_addr;
    logic [DW-1:0] st_data;
    logic [1:0]    st_size;
    logic          st_ready;
    logic          ld_valid;
    logic [AW-1:0] ld_addr;
    logic [1:0]    ld_size;
    logic          ld_sign;
    logic          ld_hit;
    logic [DW-1:0] ld_fwd_data;
    logic          ld_stall;
    logic          mem_wEn;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [1:0]    mem_size;
    logic          empty;
    logic [CW-1:0] count;

    modport master (
        output st_valid, st_addr, st_data, st_size, ld_valid, ld_addr, ld_size, ld_sign,
        input  st_ready, ld_hit, ld_fwd_data, ld_stall, mem_wEn, mem_addr, mem_wdata,
               mem_size, empty, count
    );

    modport slave (
        input  st_valid, st_addr, st_data, st_size, ld_valid, ld_addr, ld_size, ld_sign,
        output st_ready, ld_hit, ld_fwd_data, ld_stall, mem_wEn, mem_addr, mem_wdata,
               mem_size, empty, count
    );
endinterface

// File: rtl/sb_overlap.sv
// Compares one buffered store against the current load: byte-range intersection
// and exact (same address, same effective size) match.
module sb_overlap
    import mem_pkg::*;
#(
    parameter int AW = SB_AW
) (
    input  logic          e_valid_i,
    input  logic [AW-1:0] e_addr_i,
    input  logic [1:0]    e_size_i,
    input  logic [AW-1:0] ld_addr_i,
    input  logic [1:0]    ld_size_i,
    output logic          overlap_o,
    output logic          exact_o
);
    // One extra bit keeps ranges ending at the top of the address space from wrapping.
    logic [AW:0] e_lo_s, e_hi_s, l_lo_s, l_hi_s;

    always_comb begin
        e_lo_s    = {1'b0, e_addr_i};
        l_lo_s    = {1'b0, ld_addr_i};
        e_hi_s    = e_lo_s + {{(AW-2){1'b0}}, size_bytes(e_size_i)};
        l_hi_s    = l_lo_s + {{(AW-2){1'b0}}, size_bytes(ld_size_i)};
        overlap_o = e_valid_i && (e_lo_s < l_hi_s) && (l_lo_s < e_hi_s);
        exact_o   = e_valid_i && (e_addr_i == ld_addr_i) &&
                    (size_bytes(e_size_i) == size_bytes(ld_size_i));
    end
endmodule

// File: rtl/store_buffer.sv
// Posted-store FIFO between execute and DataMem with load overlap checking.
// Define STORE_BUF_FWD_EN to forward exact matches; otherwise every overlap stalls.
module store_buffer
    import mem_pkg::*;
#(
    parameter int DEPTH = SB_DEPTH,
    parameter int AW    = SB_AW,
    parameter int DW    = SB_DW
) (
    input logic          clk,
    input logic          rst,
    store_buffer_if.slave sb
);
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;

    sb_entry_t         entries_q [DEPTH];
    sb_entry_t         entries_d [DEPTH];
    logic [IW-1:0]     head_q, head_d, tail_q, tail_d;
    logic [CW-1:0]     count_q, count_d;
    logic              full_s, empty_s, enq_s, drain_s;
    logic [DEPTH-1:0]  ovl_s, exact_s;
    logic [IW-1:0]     idx_s;
    logic              found_s, sel_exact_s, hit_s, stall_s;
    logic [DW-1:0]     sel_data_s, fwd_s;

    for (genvar g = 0; g < DEPTH; g++) begin : g_ovl
        sb_overlap #(.AW(AW)) u_ovl (
            .e_valid_i (entries_q[g].valid),
            .e_addr_i  (entries_q[g].addr),
            .e_size_i  (entries_q[g].size),
            .ld_addr_i (sb.ld_addr),
            .ld_size_i (sb.ld_size),
            .overlap_o (ovl_s[g]),
            .exact_o   (exact_s[g])
        );
    end

    // Walk oldest to youngest so the last overlapping entry seen is the youngest.
    always_comb begin
        found_s     = 1'b0;
        sel_exact_s = 1'b0;
        sel_data_s  = '0;
        idx_s       = head_q;
        for (int i = 0; i < DEPTH; i++) begin
            idx_s = head_q + IW'(i);
            if (ovl_s[idx_s]) begin
                found_s     = 1'b1;
                sel_exact_s = exact_s[idx_s];
                sel_data_s  = entries_q[idx_s].data;
            end else begin
                found_s = found_s;
            end
        end
    end

`ifdef STORE_BUF_FWD_EN
    always_comb begin
        hit_s   = 1'b0;
        stall_s = 1'b0;
        fwd_s   = '0;
        if (sb.ld_valid && found_s) begin
            if (sel_exact_s) begin
                hit_s = 1'b1;
                case (sb.ld_size)
                    SZ_BYTE: fwd_s = {{(DW-8){sb.ld_sign & sel_data_s[7]}}, sel_data_s[7:0]};
                    SZ_HALF: fwd_s = {{(DW-16){sb.ld_sign & sel_data_s[15]}}, sel_data_s[15:0]};
                    default: fwd_s = sel_data_s;
                endcase
            end else begin
                stall_s = 1'b1;
            end
        end else begin
            hit_s = 1'b0;
        end
    end
`else
    logic unused_fwd_s;
    assign unused_fwd_s = ^{sel_exact_s, sel_data_s, sb.ld_sign};
    assign hit_s   = 1'b0;
    assign fwd_s   = '0;
    assign stall_s = sb.ld_valid && found_s;
`endif

    assign full_s  = (count_q == CW'(DEPTH));
    assign empty_s = (count_q == '0);
    assign enq_s   = sb.st_valid && !full_s;
    // A load that goes to DataMem owns the port; hits and stalls leave it free.
    assign drain_s = !rst && !empty_s && !(sb.ld_valid && !hit_s && !stall_s);

    assign sb.st_ready    = !full_s;
    assign sb.empty       = empty_s;
    assign sb.count       = count_q;
    assign sb.mem_wEn     = drain_s;
    assign sb.mem_addr    = empty_s ? '0 : entries_q[head_q].addr;
    assign sb.mem_wdata   = empty_s ? '0 : entries_q[head_q].data;
    assign sb.mem_size    = empty_s ? 2'b00 : entries_q[head_q].size;
    assign sb.ld_hit      = hit_s;
    assign sb.ld_stall    = stall_s;
    assign sb.ld_fwd_data = fwd_s;

    always_comb begin
        entries_d = entries_q;
        head_d    = head_q;
        tail_d    = tail_q;
        if (enq_s) begin
            entries_d[tail_q].valid = 1'b1;
            entries_d[tail_q].addr  = sb.st_addr;
            entries_d[tail_q].data  = sb.st_data;
            entries_d[tail_q].size  = sb.st_size;
            tail_d                  = tail_q + 1'b1;
        end else begin
            tail_d = tail_q;
        end
        if (drain_s) begin
            entries_d[head_q].valid = 1'b0;
            head_d                  = head_q + 1'b1;
        end else begin
            head_d = head_q;
        end
        case ({enq_s, drain_s})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                entries_q[i] <= '0;
            end
        end else begin
            head_q    <= head_d;
            tail_q    <= tail_d;
            count_q   <= count_d;
            entries_q <= entries_d;
        end
    end
endmodule

// File: doc/store_buffer.md
Name: store_buffer

Overview:
- Posted-store FIFO between the execute stage and the data-memory access stage.
- Accepts stores from execute without waiting for the memory port, then drains them into DataMem when the port is free.
- Checks in-flight loads against buffered stores: forwards on exact match, stalls on partial overlap.
- Keeps architectural memory ordering while removing store latency from the critical path.

Parameters:
- DEPTH, 4, number of store entries; power of two, 2..16.
- AW, 32, address width.
- DW, 32, data width (word size).

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- st_valid  in  1  execute presents a store this cycle.
- st_addr  in  AW  store byte address (ALU result).
- st_data  in  DW  store data (Rdata2), right-aligned.
- st_size  in  2  00 byte, 01 half, 10 word.
- st_ready  out  1  entry accepted at this edge when st_valid && st_ready.
- ld_valid  in  1  load in memory stage this cycle.
- ld_addr  in  AW  load byte address.
- ld_size  in  2  load size, same encoding as st_size.
- ld_sign  in  1  sign-extend forwarded byte/half.
- ld_hit  out  1  forwarded data valid; memory read result ignored.
- ld_fwd_data  out  DW  forwarded, extended load data.
- ld_stall  out  1  partial overlap; pipeline holds the load.
- mem_wEn  out  1  write enable to DataMem.
- mem_addr  out  AW  head-entry address.
- mem_wdata  out  DW  head-entry data.
- mem_size  out  2  head-entry size.
- empty  out  1  no buffered stores (used for fence/halt).
- count  out  log2(DEPTH)+1  occupancy.

Behaviour:
- Reset:
  - head, tail and count go to 0; all entry valid bits clear.
  - Outputs after reset: empty=1, st_ready=1, mem_wEn=0, ld_hit=0, ld_stall=0.
  - Data outputs after reset: mem_addr, mem_wdata, mem_size and ld_fwd_data are all 0.
- Storage:
  - Circular FIFO; head and tail wrap modulo DEPTH.
  - full is count==DEPTH; empty is count==0.
- Enqueue:
  - st_ready = !full, computed from registered count only.
  - A dequeue in the same cycle does not open a slot (no enqueue while full).
  - On st_valid && st_ready, write the entry at tail, then tail++.
- Drain:
  - mem_wEn = !empty && !port_busy, where port_busy = ld_valid && !ld_hit && !ld_stall.
  - mem_addr, mem_wdata and mem_size come combinationally from the head entry; they are 0 when empty.
  - When mem_wEn=1, head++ at the edge; DataMem captures the write on the same edge.
  - Minimum residency is 1 cycle: a store enqueued into an empty buffer drives mem_wEn the next cycle at the earliest.
- Count: incremented on enqueue, decremented on drain; simultaneous enqueue and drain leaves it unchanged.
- Load match, combinational over all valid entries:
  - An entry overlaps the load if their byte ranges intersect.
  - If there is no overlap, ld_hit=0 and ld_stall=0.
  - The youngest overlapping entry, searched from tail-1 back to head, decides the outcome.
  - If it has the same address and size, ld_hit=1 and ld_fwd_data = its data truncated to ld_size, sign- or zero-extended per ld_sign.
  - Any other overlap gives ld_stall=1. The buffer keeps draining during the stall, so the stall clears once the conflicting entries retire (no deadlock).
- Load sizes: word loads are never extended; size 11 is illegal and is treated as word.
- Same-cycle enqueue and load: the new store is not visible to the load in that cycle.
- Reset mid-operation discards all buffered stores. No partial write is issued; mem_wEn is 0 in the reset cycle.

Optional Feature:
- Macro: STORE_BUF_FWD_EN.
- Defined: exact-match forwarding as described in Behaviour.
- Undefined:
  - ld_hit and ld_fwd_data are tied to 0.
  - Any overlap asserts ld_stall until the overlapping entries drain.
  - Extension logic is removed.

Decomposition:
- Shared package (mem_pkg) holds:
  - size constants SZ_BYTE=2'b00, SZ_HALF=2'b01, SZ_WORD=2'b10;
  - the sb_entry_t struct (valid, addr, data, size);
  - the default DEPTH.
- One sub-module, sb_overlap: a per-entry combinational comparator (entry addr/size vs load addr/size, returning overlap and exact). It is instantiated DEPTH times.

Test Plan:
- Reset, then idle -> empty=1, st_ready=1, mem_wEn=0, count=0.
- Enqueue 5 word stores back-to-back with ld_valid held 1 and no hits -> st_ready drops after the 4th; count=4; no mem_wEn. Release ld_valid -> 4 sequential writes in FIFO order; the 5th store is accepted the cycle after the first drain.
- Store word 0x8000_00F0 @0x100, then load byte @0x100 sign=1 -> ld_hit=0 and ld_stall=1 (byte ≠ word size), stall clears after the drain. Store byte 0xF0 @0x101, then load byte @0x101 sign=1 -> ld_hit=1, ld_fwd_data=0xFFFF_FFF0; with sign=0 -> 0x0000_00F0.
- Store word @0x200, then load half @0x202 -> ld_stall=1, mem_wEn=1 that cycle; ld_stall=0 the cycle after the drain.
- Two stores to 0x300 (0x11, then 0x22, word) followed by a word load @0x300 -> forwards 0x22 (youngest entry wins).
- Assert rst with 3 entries buffered -> the next cycle empty=1 and no mem_wEn is ever issued for the discarded entries.
